prra_grant: RTL and testbench

//   Registered round-robin grant controller: the requester-facing end of the PRRA arbitration path.
//   Per-port request lines in; a one-hot grant plus encoded winner index out.

---
 rtl/prra_grant.sv | 122 ++++++++++++
 tb/tb_prra_grant.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prra_grant.sv
// Registered round-robin grant controller: rotating priority from the last winner,
// grants held until release, request drop or an optional hold timeout.
module prra_grant #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned LOG2_WIDTH   = $clog2(WIDTH),
   parameter int unsigned RESET_OFFSET = 0,
   parameter int unsigned MAX_HOLD     = 0
) (
   input  logic                  clk_i,
   input  logic                  srst_i,
   input  logic [WIDTH-1:0]      request_i,
   input  logic [WIDTH-1:0]      release_i,
   output logic [WIDTH-1:0]      grant_o,
   output logic                  grant_valid_o,
   output logic [LOG2_WIDTH-1:0] grant_index_o,
   output logic                  timeout_o
);

   localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [LOG2_WIDTH-1:0] LAST_RST = LOG2_WIDTH'(RESET_OFFSET % WIDTH);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      grant_q, grant_d;
   logic                  valid_q, valid_d;
   logic [LOG2_WIDTH-1:0] index_q, index_d;
   logic                  timeout_q, timeout_d;
   logic [LOG2_WIDTH-1:0] last_q, last_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic                  win_found;
   logic [LOG2_WIDTH-1:0] win_idx;
   logic                  own_rel, own_req, hold_hit, end_c, take_new;

   // First requester after the last winner, wrapping modulo WIDTH.
   always_comb begin
      int unsigned pos;
      win_found = 1'b0;
      win_idx   = '0;
      pos       = 0;
      for (int unsigned k = 1; k <= WIDTH; k++) begin
         pos = (32'(last_q) + k) % WIDTH;
         if (!win_found && request_i[pos]) begin
            win_found = 1'b1;
            win_idx   = LOG2_WIDTH'(pos);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      valid_d   = valid_q;
      index_d   = index_q;
      timeout_d = 1'b0;
      last_d    = last_q;
      cnt_d     = cnt_q;
      take_new  = 1'b0;
      own_rel   = release_i[index_q];
      own_req   = request_i[index_q];
      hold_hit  = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD));
      end_c     = 1'b0;

      unique case (state_q)
         S_IDLE: take_new = |request_i;
         S_GRANT: begin
            end_c = own_rel || !own_req || hold_hit;
            if (end_c) begin
               // The owner's request bit is already clear when it dropped; when it
               // released or timed out it sits at lowest priority since last_q == owner.
               timeout_d = hold_hit && !own_rel && own_req;
               take_new  = |request_i;
               if (!take_new) begin
                  state_d = S_IDLE;
                  grant_d = '0;
                  valid_d = 1'b0;
                  index_d = '0;
               end
            end else if ((MAX_HOLD != 0) && (cnt_q < CW'(MAX_HOLD))) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take_new && win_found) begin
         state_d = S_GRANT;
         grant_d = WIDTH'(1) << win_idx;
         valid_d = 1'b1;
         index_d = win_idx;
         last_d  = win_idx;
         cnt_d   = CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         timeout_q <= 1'b0;
         last_q    <= LAST_RST;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         index_q   <= index_d;
         timeout_q <= timeout_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_valid_o = valid_q;
   assign grant_index_o = index_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_prra_grant.sv
// Bench for prra_grant: directed scenarios plus random traffic, checked against an
// arbitration model through a per-cycle expected-output queue.
module tb_prra_grant;

   localparam int W     = 4;
   localparam int MAXH  = 8;
   localparam int ROFF  = 0;

   logic           clk = 1'b0;
   logic           srst = 1'b1;
   logic [W-1:0]   request = '0;
   logic [W-1:0]   release_v = '0;
   logic [W-1:0]   grant;
   logic           grant_valid;
   logic [1:0]     grant_index;
   logic           timeout;

   typedef struct packed {
      logic [W-1:0] g;
      logic         v;
      logic [1:0]   idx;
      logic         to;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // model state: owner = -1 means nobody holds the grant
   int m_owner = -1;
   int m_last  = ROFF % W;
   int m_cnt   = 0;
   bit m_to    = 0;

   prra_grant #(
      .WIDTH(W), .LOG2_WIDTH(2), .RESET_OFFSET(ROFF), .MAX_HOLD(MAXH)
   ) u_dut (
      .clk_i(clk), .srst_i(srst), .request_i(request), .release_i(release_v),
      .grant_o(grant), .grant_valid_o(grant_valid), .grant_index_o(grant_index),
      .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   function automatic int scan(input logic [W-1:0] rq, input int last);
      for (int k = 1; k <= W; k++) begin
         if (rq[(last + k) % W]) return (last + k) % W;
      end
      return -1;
   endfunction

   task automatic model_step(input logic s, input logic [W-1:0] rq, input logic [W-1:0] rl);
      int  w;
      bit  a, b, c;
      m_to = 0;
      if (s) begin
         m_owner = -1; m_last = ROFF % W; m_cnt = 0;
      end else if (m_owner < 0) begin
         w = scan(rq, m_last);
         if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 1; end
      end else begin
         a = rl[m_owner];
         b = !rq[m_owner];
         c = (MAXH != 0) && (m_cnt == MAXH);
         m_to = c && !a && !b;
         if (a || b || c) begin
            w = scan(rq, m_last);
            if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 1; end
            else m_owner = -1;
         end else if (m_cnt < MAXH) begin
            m_cnt++;
         end
      end
   endtask

   task automatic drive(input logic s, input logic [W-1:0] rq, input logic [W-1:0] rl);
      exp_t e;
      @(negedge clk);
      srst = s; request = rq; release_v = rl;
      model_step(s, rq, rl);
      e.g   = (m_owner < 0) ? '0 : W'(1) << m_owner;
      e.v   = (m_owner >= 0);
      e.idx = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      e.to  = m_to;
      exp_q.push_back(e);
   endtask

   function automatic logic [W-1:0] owner_bit();
      return (m_owner < 0) ? '0 : W'(1) << m_owner;
   endfunction

   // Monitor: every clock edge the DUT presents a new output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (grant !== e.g || grant_valid !== e.v || grant_index !== e.idx || timeout !== e.to) begin
               failures++;
               $display("FAIL outputs t=%0t got grant=%b valid=%b idx=%0d to=%b want grant=%b valid=%b idx=%0d to=%b",
                        $time, grant, grant_valid, grant_index, timeout, e.g, e.v, e.idx, e.to);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] rq;
      logic [W-1:0] rl;
      drive(1, '0, '0);
      drive(1, '0, '0);
      // first grant after reset, then idle
      drive(0, 4'b0001, '0);
      drive(0, 4'b0001, '0);
      drive(0, 4'b0000, '0);
      // all requesting, owner releases every third cycle
      for (int i = 0; i < 15; i++) drive(0, 4'b1111, (i % 3 == 2) ? owner_bit() : '0);
      // stray release ignored, owner release with sole request re-wins
      drive(1, '0, '0);
      drive(0, 4'b0100, '0);
      drive(0, 4'b0110, 4'b0010);
      drive(0, 4'b0110, 4'b1011);
      drive(0, 4'b0100, 4'b0100);
      drive(0, 4'b0100, '0);
      drive(0, '0, 4'b0100);
      drive(0, '0, 4'b1111);
      // hold timeout with two requesters
      drive(1, '0, '0);
      for (int i = 0; i < 22; i++) drive(0, 4'b0011, '0);
      // timeout and release together: no pulse
      drive(1, '0, '0);
      for (int i = 0; i < 8; i++) drive(0, 4'b0011, '0);
      drive(0, 4'b0011, 4'b0010);
      drive(0, 4'b0011, '0);
      // request drop ends grant
      drive(1, '0, '0);
      drive(0, 4'b1000, '0);
      drive(0, 4'b1000, '0);
      drive(0, 4'b0000, '0);
      drive(0, 4'b0000, '0);
      // reset mid-grant, pointer back to reset offset
      drive(0, 4'b0100, '0);
      drive(0, 4'b0100, '0);
      drive(1, 4'b1111, 4'b0100);
      drive(0, 4'b1111, '0);
      drive(0, 4'b1111, '0);
      // random traffic
      rq = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rq = W'($urandom_range(0, 15));
         rl = ($urandom_range(0, 5) == 0) ? owner_bit() : '0;
         if ($urandom_range(0, 3) == 0) rl = rl | W'($urandom_range(0, 15));
         drive(($urandom_range(0, 99) == 0), rq, rl);
      end
      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
